pipeline_result_fifo: RTL and testbench
=======================================

Name: pipeline_result_fifo

Overview:
- Downstream consumer of the 3-stage arithmetic pipeline, which computes f = ((a+b)+(c-d))*d with no valid or stall.
- Tracks which issue cycles carry real operands using a valid delay line matched to the pipeline latency.
- Captures the matching f results into a small FIFO and presents them on a ready/valid interface.
- Drives a credit signal to the issuer so the free-running pipeline never produces a result the FIFO cannot hold.

Parameters:
- N, 10, data width; must equal the pipeline width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- LAT, 3, pipeline register stages between operand capture and f.

Ports:
- clk  in  1  rising-edge clock, shared with the pipeline.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands a..d presented to the pipeline this cycle are real.
- issue_ok  out  1  credit: issuer may assert in_valid this cycle.
- f_in  in  N  pipeline output f.
- out_data  out  N  FIFO head.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  consumer accepts the head.
- count  out  $clog2(DEPTH)+1  number of stored entries.
- overflow  out  1  sticky: a result was dropped.

Behaviour:
- One clock; reset is asynchronous and active-high. Clock port clk, reset port rst.
- Reset values:
  - All delay-line bits 0, read and write pointers 0.
  - count 0, out_valid 0, overflow 0, out_data 0.
- Delay line: LAT flops, v[0] <= in_valid, v[i] <= v[i-1].
  - v[LAT-1] is high exactly in the cycle in which f_in reflects the operands issued with that in_valid.
- Latency: in_valid sampled at edge k -> result pushed at edge k+LAT -> out_valid high after edge k+LAT.
  - With LAT=3 the result is visible 3 cycles after issue, 4 edges from issue to first possible pop.
- push = v[LAT-1]. pop = out_valid & out_ready.
- FIFO is show-ahead: out_data = mem[rd_ptr] and out_valid = (count != 0), both decoded from registered state.
- Pointers use log2(DEPTH) bits and wrap naturally.
- Simultaneous push and pop:
  - count unchanged.
  - Allowed when full: the push is accepted because pop frees the head slot in the same edge.
  - When empty, the pop is impossible (out_valid low), so only the push occurs.
- Push when full without pop:
  - The entry is discarded and storage is unchanged.
  - overflow is set and stays set until rst.
- Pop when empty: impossible (out_valid low); out_ready is ignored.
- issue_ok (combinational) = (count + popcount(v[0..LAT-1])) < DEPTH.
  - Counts in-flight results as already occupying slots.
  - If the issuer obeys issue_ok, overflow never sets.
- in_valid while issue_ok is low is not blocked; the result may later overflow.
- Data is taken unmodified; f_in is already modulo 2^N from the pipeline.
- Reset mid-operation:
  - In-flight tags and stored entries are lost and outputs return to reset values immediately.
  - The pipeline keeps producing stale f values, but they are never pushed because the delay line is cleared.

Optional Feature:
- Macro: PIPE_RESULT_STATS_EN.
- Defined:
  - Adds outputs stat_pushed[15:0] (accepted pushes) and stat_dropped[15:0] (overflow drops).
  - Both are saturating at 16'hFFFF and reset to 0 by rst.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - Constant PIPE_N = 10 and PIPE_LAT = 3, shared with the pipeline.
  - Typedef pipe_data_t = logic [PIPE_N-1:0].
- Natural sub-module: pipe_valid_delay (LAT-deep shift register plus popcount output) feeding the FIFO core in the top.

Test Plan:
- Single issue, LAT=3: a=3, b=4, c=10, d=2 with in_valid one cycle -> out_valid rises 3 cycles later with out_data = 30; pop with out_ready=1 -> count returns to 0.
- Back-to-back issues: d=1, and (a+b)+(c-d) = 1, 2, 3, 4, 5 on 5 consecutive in_valid cycles with out_ready=0 and issuer obeying issue_ok.
  - Only 4 are issued before issue_ok drops.
  - count reaches 4 and overflow stays 0.
  - Draining yields 1, 2, 3, 4 in order.
- Forced overflow: ignore issue_ok and issue 6 results with out_ready=0.
  - count = 4, overflow = 1.
  - Stored data are the first 4 results.
  - With PIPE_RESULT_STATS_EN: stat_pushed = 4, stat_dropped = 2.
- Full plus simultaneous push and pop: FIFO full, out_ready=1 in the cycle a result arrives.
  - count stays 4, no overflow.
  - Output order is preserved across pointer wrap.
- Width wrap: a=0, b=0, c=600, d=2 -> (0-2+... ) computed modulo 1024 by the pipeline. Expected f = ((0+0)+(600-2))*2 mod 1024 = 172; out_data = 172.
- Async reset: assert rst mid-stream with 2 stored and 2 in flight.
  - Outputs clear without waiting for a clock edge.
  - After release, no stale results appear even though f_in keeps changing.

Source files
------------

// File: rtl/pipe_pkg.sv
// Constants and types shared by the arithmetic pipeline and its result FIFO.
package pipe_pkg;
  localparam int PIPE_N   = 10;
  localparam int PIPE_LAT = 3;

  typedef logic [PIPE_N-1:0] pipe_data_t;
endpackage

// File: rtl/pipe_valid_delay.sv
// Valid tag delay line matched to the pipeline latency.
// Also reports how many tagged results are still in flight.
module pipe_valid_delay
  import pipe_pkg::*;
#(
  parameter int LAT = PIPE_LAT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       tail,
  output logic [$clog2(LAT+1)-1:0]   in_flight
);
  localparam int FW = $clog2(LAT + 1);

  logic [LAT-1:0] v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
    end else begin
      v[0] <= in_valid;
      for (int i = 1; i < LAT; i++) begin
        v[i] <= v[i-1];
      end
    end
  end

  assign tail = v[LAT-1];

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < LAT; i++) begin
      in_flight = in_flight + FW'(v[i]);
    end
  end
endmodule

// File: rtl/pipeline_result_fifo.sv
// Result FIFO behind the free-running pipeline, with credit-based issue control.
// Define PIPE_RESULT_STATS_EN to add saturating push/drop statistics counters.
module pipeline_result_fifo
  import pipe_pkg::*;
#(
  parameter int N     = PIPE_N,
  parameter int DEPTH = 4,
  parameter int LAT   = PIPE_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     issue_ok,
  input  logic [N-1:0]             f_in,
  output logic [N-1:0]             out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
`ifdef PIPE_RESULT_STATS_EN
  ,
  output logic [15:0]              stat_pushed,
  output logic [15:0]              stat_dropped
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = $clog2(LAT + 1);
  localparam int SW = $clog2(DEPTH + LAT + 1);

  logic [N-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic          full;
  logic          do_write;
  logic          drop;
  logic [FW-1:0] in_flight;

  pipe_valid_delay #(.LAT(LAT)) u_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .tail      (push),
    .in_flight (in_flight)
  );

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid & out_ready;
  assign full      = (count == CW'(DEPTH));
  // A pop in the same edge frees the head slot, so a full FIFO can still accept.
  assign do_write  = push & (~full | pop);
  assign drop      = push & full & ~pop;
  // In-flight results are treated as already occupying a slot.
  assign issue_ok  = (SW'(count) + SW'(in_flight)) < SW'(DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_write) begin
      mem[wr_ptr] <= f_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PW'(1);
      if (pop)      rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_write, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

`ifdef PIPE_RESULT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_pushed  <= '0;
      stat_dropped <= '0;
    end else begin
      if (do_write && stat_pushed != 16'hFFFF)  stat_pushed  <= stat_pushed + 16'd1;
      if (drop && stat_dropped != 16'hFFFF)     stat_dropped <= stat_dropped + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_result_fifo.sv
// Directed bench: a behavioural 3-stage pipeline f = ((a+b)+(c-d))*d feeds the result FIFO.
module tb_pipeline_result_fifo;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        issue_ok;
  pipe_data_t  f_in;
  pipe_data_t  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  count;
  logic        overflow;
`ifdef PIPE_RESULT_STATS_EN
  logic [15:0] stat_pushed;
  logic [15:0] stat_dropped;
`endif

  pipe_data_t a = '0, b = '0, c = '0, d = '0;
  pipe_data_t p1_ab = '0, p1_cd = '0, p1_d = '0, p2_sum = '0, p2_d = '0, f_reg = '0;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pipeline_result_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .issue_ok  (issue_ok),
    .f_in      (f_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow)
`ifdef PIPE_RESULT_STATS_EN
    ,
    .stat_pushed  (stat_pushed),
    .stat_dropped (stat_dropped)
`endif
  );

  // Free-running upstream pipeline: no reset, no valid, three register stages.
  always @(posedge clk) begin
    p1_ab  <= a + b;
    p1_cd  <= c - d;
    p1_d   <= d;
    p2_sum <= p1_ab + p1_cd;
    p2_d   <= p1_d;
    f_reg  <= p2_sum * p2_d;
  end
  assign f_in = f_reg;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Presents operands for one cycle and returns 1 time unit after the edge.
  task automatic applyStimulus(input logic v, input int ia, input int ib, input int ic, input int id);
    in_valid = v;
    a = pipe_data_t'(ia);
    b = pipe_data_t'(ib);
    c = pipe_data_t'(ic);
    d = pipe_data_t'(id);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 7 * i + 5, 3 * i, 100 + i, i + 1);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int issued;
    int nextVal;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    checkOutput("reset_count",     count,     0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_overflow",  overflow,  0);
    checkOutput("reset_out_data",  out_data,  0);
    checkOutput("reset_issue_ok",  issue_ok,  1);
    idle(2);
    rst = 1'b0;

    // Single issue: ((3+4)+(10-2))*2 = 30
    applyStimulus(1'b1, 3, 4, 10, 2);
    checkOutput("single_issue_ok", issue_ok, 1);
    idle(2);
    checkOutput("single_not_early", out_valid, 0);
    idle(1);
    checkOutput("single_valid", out_valid, 1);
    checkOutput("single_data",  out_data,  30);
    checkOutput("single_count", count,     1);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    checkOutput("single_popped", count, 0);

    // Back-to-back issues obeying the credit
    issued  = 0;
    nextVal = 1;
    for (int i = 0; i < 5; i++) begin
      if (issue_ok) begin
        applyStimulus(1'b1, nextVal, 0, 1, 1);
        nextVal++;
        issued++;
      end else begin
        applyStimulus(1'b0, 0, 0, 0, 0);
      end
    end
    checkOutput("b2b_issued", issued, 4);
    idle(4);
    checkOutput("b2b_count",    count,    4);
    checkOutput("b2b_overflow", overflow, 0);
    checkOutput("b2b_issue_ok", issue_ok, 0);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checkOutput("b2b_drain", out_data, i);
      idle(1);
    end
    out_ready = 1'b0;
    checkOutput("b2b_empty", count, 0);

    // Forced overflow: six issues ignoring the credit
    pulseReset();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 11 + i, 0, 1, 1);
    idle(4);
    checkOutput("ovf_count",    count,    4);
    checkOutput("ovf_overflow", overflow, 1);
`ifdef PIPE_RESULT_STATS_EN
    checkOutput("ovf_stat_pushed",  stat_pushed,  4);
    checkOutput("ovf_stat_dropped", stat_dropped, 2);
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("ovf_data", out_data, 11 + i);
      idle(1);
    end
    out_ready = 1'b0;
    checkOutput("ovf_sticky", overflow, 1);

    // Full FIFO with a push and pop on the same edge, across pointer wrap
    pulseReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 21 + i, 0, 1, 1);
    idle(3);
    checkOutput("full_count", count, 4);
    applyStimulus(1'b1, 25, 0, 1, 1);
    idle(2);
    checkOutput("full_head", out_data, 21);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    checkOutput("full_pp_count",    count,    4);
    checkOutput("full_pp_overflow", overflow, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("full_wrap_data", out_data, 22 + i);
      idle(1);
    end
    out_ready = 1'b0;
    checkOutput("full_wrap_empty", count, 0);

    // Width wrap: ((0+0)+(600-2))*2 mod 1024 = 172
    applyStimulus(1'b1, 0, 0, 600, 2);
    idle(3);
    checkOutput("wrap_valid", out_valid, 1);
    checkOutput("wrap_data",  out_data,  172);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;

    // Async reset with two stored and two in flight
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 31 + i, 0, 1, 1);
    idle(1);
    checkOutput("rst_pre_count", count, 2);
    rst = 1'b1;
    #1;
    checkOutput("rst_async_count",    count,     0);
    checkOutput("rst_async_valid",    out_valid, 0);
    checkOutput("rst_async_data",     out_data,  0);
    checkOutput("rst_async_issue_ok", issue_ok,  1);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      checkOutput("rst_no_stale", count, 0);
    end
    checkOutput("rst_no_stale_valid", out_valid, 0);
    checkOutput("rst_overflow",       overflow,  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
